// File: rtl/rl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rl_pkg
//  Description : Shared widths, types, FSM encoding and saturation helper for
//                the Q-learning update datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package rl_pkg;

  localparam int DEF_STATE_W     = 4;
  localparam int DEF_ACT_W       = 2;
  localparam int DEF_Q_W         = 8;
  localparam int DEF_ALPHA_SHIFT = 2;
  localparam int DEF_GAMMA_SHIFT = 1;

  typedef logic signed [DEF_Q_W-1:0] q_t;
  typedef logic [DEF_ACT_W-1:0]      action_t;
  typedef logic [DEF_STATE_W-1:0]    state_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LAST  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4
  } fsm_state_t;

  // Clamp a signed value to the range of a signed field of the given width.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_update_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : q_update_ctrl_if
//  Description : Request handshake plus qtable/policytable ports of the
//                Q-update sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface q_update_ctrl_if #(
  parameter int STATE_W = rl_pkg::DEF_STATE_W,
  parameter int ACT_W   = rl_pkg::DEF_ACT_W,
  parameter int Q_W     = rl_pkg::DEF_Q_W
);
  logic                        i_start;
  logic                        o_ready;
  logic [STATE_W-1:0]          i_state;
  logic [STATE_W-1:0]          i_next_state;
  logic [ACT_W-1:0]            i_action;
  logic signed [Q_W-1:0]       i_reward;
  logic [STATE_W+ACT_W-1:0]    o_q_addr_r;
  logic [STATE_W+ACT_W-1:0]    o_q_addr_w;
  logic                        o_q_rd_en;
  logic                        o_q_wr_en;
  logic signed [Q_W-1:0]       o_q_wdata;
  logic signed [Q_W-1:0]       i_q_rdata;
  logic [STATE_W-1:0]          o_p_addr_w;
  logic                        o_p_wr_en;
  logic [ACT_W-1:0]            o_p_wdata;
  logic                        o_done;
  logic [ACT_W-1:0]            o_best_action;

  modport slave (
    input  i_start, i_state, i_next_state, i_action, i_reward, i_q_rdata,
    output o_ready, o_q_addr_r, o_q_addr_w, o_q_rd_en, o_q_wr_en, o_q_wdata,
           o_p_addr_w, o_p_wr_en, o_p_wdata, o_done, o_best_action
  );

  modport master (
    output i_start, i_state, i_next_state, i_action, i_reward, i_q_rdata,
    input  o_ready, o_q_addr_r, o_q_addr_w, o_q_rd_en, o_q_wr_en, o_q_wdata,
           o_p_addr_w, o_p_wr_en, o_p_wdata, o_done, o_best_action
  );
endinterface
`default_nettype wire

// File: rtl/q_argmax_acc.sv
`default_nettype none
// ============================================================================
//  Module      : q_argmax_acc
//  Description : Streaming signed max/argmax; ties keep the earliest index.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_argmax_acc #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_max,
  output logic [IDX_W-1:0]         o_index
);
  logic [IDX_W-1:0]         r_count;
  logic                     r_have;
  logic signed [DATA_W-1:0] r_max;
  logic [IDX_W-1:0]         r_index;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
      r_have  <= 1'b0;
      r_max   <= '0;
      r_index <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_have  <= 1'b0;
    end else if (i_valid) begin
      // First datum seeds the max; afterwards only a strictly larger value wins.
      if (!r_have || (i_data > r_max)) begin
        r_max   <= i_data;
        r_index <= r_count;
      end
      r_count <= r_count + IDX_W'(1);
      r_have  <= 1'b1;
    end
  end

  assign o_max   = r_max;
  assign o_index = r_index;
endmodule
`default_nettype wire

// File: rtl/q_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : q_update_ctrl
//  Description : Sequences one shift-based Bellman update: greedy scan of
//                Q(s',.), read of Q(s,a), saturating update, table writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_update_ctrl import rl_pkg::*; #(
  parameter int STATE_W     = DEF_STATE_W,
  parameter int ACT_W       = DEF_ACT_W,
  parameter int Q_W         = DEF_Q_W,
  parameter int ALPHA_SHIFT = DEF_ALPHA_SHIFT,
  parameter int GAMMA_SHIFT = DEF_GAMMA_SHIFT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  q_update_ctrl_if.slave bus
);
  localparam int c_num_act = 2 ** ACT_W;
  localparam int c_addr_w  = STATE_W + ACT_W;
  localparam int c_k_w     = ACT_W + 1;
  localparam int c_calc_w  = Q_W + 2;
  localparam logic [c_k_w-1:0] c_k_last = c_k_w'(c_num_act);

  fsm_state_t            r_state;
  logic [c_k_w-1:0]      r_k;
  logic [STATE_W-1:0]    r_s;
  logic [STATE_W-1:0]    r_sn;
  logic [ACT_W-1:0]      r_a;
  logic signed [Q_W-1:0] r_reward;
  logic signed [Q_W-1:0] r_q_sa;
  logic                  r_ready;
  logic                  r_rd_en;
  logic [c_addr_w-1:0]   r_addr_r;
  logic                  r_wr_en;
  logic [c_addr_w-1:0]   r_addr_w;
  logic signed [Q_W-1:0] r_wdata;
  logic                  r_p_wr_en;
  logic [STATE_W-1:0]    r_p_addr_w;
  logic [ACT_W-1:0]      r_p_wdata;
  logic                  r_done;
  logic [ACT_W-1:0]      r_best;

  logic                       w_acc_clear;
  logic                       w_acc_valid;
  logic signed [Q_W-1:0]      w_acc_max;
  logic [ACT_W-1:0]           w_acc_idx;
  logic [c_k_w-1:0]           w_k_next;
  logic signed [c_calc_w-1:0] w_max_ext;
  logic signed [c_calc_w-1:0] w_r_ext;
  logic signed [c_calc_w-1:0] w_qsa_ext;
  logic signed [c_calc_w-1:0] w_target;
  logic signed [c_calc_w-1:0] w_delta;
  logic signed [c_calc_w-1:0] w_q_new;
  logic signed [Q_W-1:0]      w_q_sat;

  // Read data trails its address by one cycle, so READ with k>0 sees Q(s',k-1).
  assign w_acc_clear = (r_state == S_IDLE);
  assign w_acc_valid = (r_state == S_READ) && (r_k != '0);
  assign w_k_next    = r_k + c_k_w'(1);

  q_argmax_acc #(
    .DATA_W (Q_W),
    .IDX_W  (ACT_W)
  ) u_argmax (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_acc_clear),
    .i_valid (w_acc_valid),
    .i_data  (bus.i_q_rdata),
    .o_max   (w_acc_max),
    .o_index (w_acc_idx)
  );

  always_comb begin
    w_max_ext = {{2{w_acc_max[Q_W-1]}}, w_acc_max};
    w_r_ext   = {{2{r_reward[Q_W-1]}}, r_reward};
    w_qsa_ext = {{2{r_q_sa[Q_W-1]}}, r_q_sa};
    w_target  = w_r_ext + (w_max_ext >>> GAMMA_SHIFT);
    w_delta   = w_target - w_qsa_ext;
    w_q_new   = w_qsa_ext + (w_delta >>> ALPHA_SHIFT);
    w_q_sat   = Q_W'(saturate(32'(w_q_new), Q_W));
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_s        <= '0;
      r_sn       <= '0;
      r_a        <= '0;
      r_reward   <= '0;
      r_q_sa     <= '0;
      r_ready    <= 1'b1;
      r_rd_en    <= 1'b0;
      r_addr_r   <= '0;
      r_wr_en    <= 1'b0;
      r_addr_w   <= '0;
      r_wdata    <= '0;
      r_p_wr_en  <= 1'b0;
      r_p_addr_w <= '0;
      r_p_wdata  <= '0;
      r_done     <= 1'b0;
      r_best     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_s      <= bus.i_state;
            r_sn     <= bus.i_next_state;
            r_a      <= bus.i_action;
            r_reward <= bus.i_reward;
            r_ready  <= 1'b0;
            r_k      <= '0;
            r_rd_en  <= 1'b1;
            r_addr_r <= {bus.i_next_state, ACT_W'(0)};
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (r_k == c_k_last) begin
            r_rd_en  <= 1'b0;
            r_addr_r <= '0;
            r_state  <= S_LAST;
          end else begin
            r_k      <= w_k_next;
            r_addr_r <= (w_k_next == c_k_last) ? {r_s, r_a}
                                               : {r_sn, w_k_next[ACT_W-1:0]};
          end
        end
        S_LAST: begin
          r_q_sa  <= bus.i_q_rdata;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_wr_en    <= 1'b1;
          r_addr_w   <= {r_s, r_a};
          r_wdata    <= w_q_sat;
          r_p_wr_en  <= 1'b1;
          r_p_addr_w <= r_sn;
          r_p_wdata  <= w_acc_idx;
          r_done     <= 1'b1;
          r_best     <= w_acc_idx;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          r_wr_en    <= 1'b0;
          r_addr_w   <= '0;
          r_wdata    <= '0;
          r_p_wr_en  <= 1'b0;
          r_p_addr_w <= '0;
          r_p_wdata  <= '0;
          r_done     <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_rd_en   <= 1'b0;
          r_wr_en   <= 1'b0;
          r_p_wr_en <= 1'b0;
          r_done    <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready       = r_ready;
  assign bus.o_q_rd_en     = r_rd_en;
  assign bus.o_q_addr_r    = r_addr_r;
  assign bus.o_q_wr_en     = r_wr_en;
  assign bus.o_q_addr_w    = r_addr_w;
  assign bus.o_q_wdata     = r_wdata;
  assign bus.o_p_wr_en     = r_p_wr_en;
  assign bus.o_p_addr_w    = r_p_addr_w;
  assign bus.o_p_wdata     = r_p_wdata;
  assign bus.o_done        = r_done;
  assign bus.o_best_action = r_best;
endmodule
`default_nettype wire

// File: doc/q_update_ctrl.md
# q_update_ctrl

Sequencer for one tabular Q-learning update over the shared `qtable` / `policytable` pair. On each accepted request it:
- scans Q(s′,·) for the greedy maximum;
- reads Q(s,a) and computes the shift-based Bellman update with saturation;
- writes the new Q(s,a) to `qtable` and the greedy action for s′ to `policytable`.

It is the only master of both tables' ports; the agent front-end drives it with one request at a time.

## Interface
Parameters:
- STATE_W, 4, state index width (2**STATE_W states)
- ACT_W, 2, action index width (NUM_ACT = 2**ACT_W = 4 actions)
- Q_W, 8, signed two's-complement Q-value and reward width
- ALPHA_SHIFT, 2, learning rate α = 2^-ALPHA_SHIFT
- GAMMA_SHIFT, 1, discount γ = 2^-GAMMA_SHIFT

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_start  in  1  request valid
- o_ready  out  1  high only in IDLE; request accepted on i_start && o_ready
- i_state, i_next_state  in  STATE_W  s, s′
- i_action  in  ACT_W  a
- i_reward  in  Q_W  signed r
- o_q_addr_r, o_q_addr_w  out  STATE_W+ACT_W  qtable address {state, action}
- o_q_rd_en, o_q_wr_en  out  1  qtable enables
- o_q_wdata  out  Q_W  new Q(s,a)
- i_q_rdata  in  Q_W  qtable read data, valid 1 cycle after o_q_rd_en
- o_p_addr_w  out  STATE_W  policytable write address (= s′)
- o_p_wr_en  out  1  policytable write enable
- o_p_wdata  out  ACT_W  greedy action for s′
- o_done  out  1  one-cycle pulse, coincident with the writes
- o_best_action  out  ACT_W  argmax from the last scan; held until the next update

## Operation
- Request capture: s, a, s′ and r are registered at acceptance. Inputs are ignored while o_ready = 0, and there is no queueing.
- FSM states and transitions: IDLE → READ → LAST → CALC → WRITE → IDLE.
- READ (5 cycles, counter k = 0..4): o_q_rd_en = 1.
  - o_q_addr_r = {s′, k} for k = 0..3.
  - o_q_addr_r = {s, a} for k = 4.
- Data capture: each datum is captured one cycle after its read is issued. LAST captures the fifth datum, Q(s,a).
- Max/argmax: running compare with strict greater-than, so a tie keeps the lowest action index. The first datum initialises the maximum.
- CALC (all arithmetic in Q_W+2 signed bits):
  - target = r + (maxQ >>> GAMMA_SHIFT)
  - delta = target − Q(s,a)
  - q_new = Q(s,a) + (delta >>> ALPHA_SHIFT)
  - q_new is saturated to [−2^(Q_W−1), 2^(Q_W−1)−1].
- WRITE (1 cycle):
  - qtable: o_q_wr_en = 1, o_q_addr_w = {s,a}, o_q_wdata = q_new.
  - policytable: o_p_wr_en = 1, o_p_addr_w = s′, o_p_wdata = argmax.
  - o_done = 1 and o_best_action updates.
- s′ == s: the scan reads pre-update values of the same row. This is the required behaviour; no forwarding.
- Reset values (all outputs):
  - o_ready = 1.
  - All enables and o_done = 0.
  - All addresses, data and o_best_action = 0.
  - FSM returns to IDLE.
- Reset mid-operation: enables drop immediately (asynchronous) and no write occurs. The aborted request is lost and must be reissued.
- Write-only outputs: o_q_wdata, o_q_addr_w, o_p_* are don't-care when their enable is low, but are driven 0 outside WRITE.

## Timing
- Acceptance edge = cycle 0.
- o_q_rd_en is high in cycles 1–5.
- LAST = cycle 6, CALC = cycle 7.
- WRITE and o_done = cycle 8.
- o_ready rises in cycle 9. With i_start held high, the next request is accepted at the end of cycle 9, giving a throughput of one update per 9 cycles.
- qtable read latency is exactly 1 cycle. Read and write are never enabled in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `rl_pkg` holds:
  - default STATE_W, ACT_W, Q_W, ALPHA_SHIFT, GAMMA_SHIFT;
  - the FSM state enum;
  - q_t, action_t and state_t typedefs;
  - a saturate function.
- One sub-module: `q_argmax_acc`, the streaming max/argmax accumulator (clear, valid, data in; max, index out), reusable by the greedy-action selector.

## Test plan
Default parameters throughout.
- **Zero tables:** s=1, a=2, s′=3, r=8, all Q=0 → write addr 6 data 2; policy addr 3 data 0; o_done at cycle 8.
- **Zero delta, tie:** Q(3,·)={4,20,20,−5}, Q(1,2)=10, r=0 → max 20, argmax 1 (tie to lowest); q_new 10; policy data 1.
- **Saturation:**
  - Q(1,2)=127, r=127, Q(3,·) max 127 → q_new 127 (raw 142).
  - Q=−128, r=−128, max −128 → q_new −128 (raw −144).
- **Reset during READ:** assert i_rst low at cycle 3 → all enables 0 immediately; no wr_en ever; o_ready=1 after release; a fresh request completes normally.
- **Busy and back-to-back:** i_start pulses at cycles 2–7 are ignored. i_start held high accepts the next request at cycle 9, and the second o_done lands at cycle 17.
- **s′ == s:** s=s′=5, a=0, Q(5,·)={8,0,0,0}, r=0 → max 8, argmax 0; target 4; q_new 7; write addr 20.
